// File: rtl/cache_pkg.sv
// Shared definitions between the fetch stage and the L1 cache interface:
// status codes, access flags, fetch FSM states and the buffered entry layout.
package cache_pkg;

    localparam logic [1:0] WAITING_FOR_MEM_READ = 2'd1;
    localparam logic [1:0] CACHE_HIT            = 2'd2;
    localparam logic [1:0] CACHE_MISS           = 2'd3;

    localparam logic [1:0] READ_SIGNAL  = 2'd1;
    localparam logic [1:0] WRITE_SIGNAL = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH     = 2'd1,
        MISS_WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with registered storage; flush empties it and wins
// over any push or pop presented in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage in front of the L1 cache: owns the PC, holds the address across
// misses, buffers {pc, instr} toward decode and applies redirects at safe points.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    SIZE       = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2,
    parameter int                    PC_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    output logic                  cache_enable,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [1:0]            cache_rd_wr_evict_flag,
    input  logic [SIZE-1:0]       cache_read_data,
    input  logic [1:0]            cache_data_available,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIZE-1:0]       out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  busy
);

    import cache_pkg::*;

    localparam int ENTRY_W = ADDR_WIDTH + SIZE;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;

    logic                  is_hit;
    logic                  is_wait;
    logic [ADDR_WIDTH-1:0] redirect_tgt;
    logic                  fifo_push;
    logic                  fifo_flush;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [ENTRY_W-1:0]    fifo_rdata;
    logic                  unused_redirect_lsb;

    assign is_hit              = (cache_data_available == CACHE_HIT);
    assign is_wait             = (cache_data_available == WAITING_FOR_MEM_READ) ||
                                 (cache_data_available == CACHE_MISS);
    assign redirect_tgt        = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (run) state_d = FETCH;
            FETCH: begin
                if (is_wait)   state_d = MISS_WAIT;
                else if (!run) state_d = IDLE;
            end
            MISS_WAIT: if (is_hit) state_d = run ? FETCH : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // A status of 2 is the only safe point to move the PC; until then any
    // redirect is parked in pend_pc so the cache sees a stable address.
    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        fifo_push  = 1'b0;
        fifo_flush = redirect_valid;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d   = redirect_tgt;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    pc_d   = pend_pc_q;
                    pend_d = 1'b0;
                end
            end
            FETCH, MISS_WAIT: begin
                if (is_hit) begin
                    if (redirect_valid) begin
                        pc_d   = redirect_tgt;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        pc_d   = pend_pc_q;
                        pend_d = 1'b0;
                    end else if (!fifo_full) begin
                        fifo_push = 1'b1;
                        pc_d      = pc_q + ADDR_WIDTH'(PC_STEP);
                    end
                end else if (redirect_valid) begin
                    pend_d    = 1'b1;
                    pend_pc_d = redirect_tgt;
                end
            end
            default: ;
        endcase
    end

    assign cache_enable           = (state_q != IDLE);
    assign busy                   = (state_q != IDLE);
    assign cache_addr             = pc_q;
    assign cache_rd_wr_evict_flag = cache_enable ? READ_SIGNAL : 2'd0;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (out_ready),
        .flush (fifo_flush),
        .wdata ({pc_q, cache_read_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid          = !fifo_empty;
    assign {out_pc, out_instr} = fifo_rdata;

    fifo_count_bound: assert property (
        @(posedge clk) disable iff (reset) fifo_count <= CNT_W'(FIFO_DEPTH)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a scripted cache model, stimulus that
// queues hand-computed {pc, instr} results, and a monitor that checks outputs.
module tb_instr_fetch_unit;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int EW = AW + DW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          run = 1'b0;
    logic          cache_enable;
    logic [AW-1:0] cache_addr;
    logic [1:0]    cache_rd_wr_evict_flag;
    logic [DW-1:0] cache_read_data;
    logic [1:0]    cache_data_available;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic          busy;

    logic          use_force = 1'b0;
    logic [1:0]    force_status = 2'd0;
    logic [DW-1:0] force_data = '0;

    logic [EW-1:0] exp_q[$];
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk                    (clk),
        .reset                  (reset),
        .run                    (run),
        .cache_enable           (cache_enable),
        .cache_addr             (cache_addr),
        .cache_rd_wr_evict_flag (cache_rd_wr_evict_flag),
        .cache_read_data        (cache_read_data),
        .cache_data_available   (cache_data_available),
        .redirect_valid         (redirect_valid),
        .redirect_pc            (redirect_pc),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .out_instr              (out_instr),
        .out_pc                 (out_pc),
        .busy                   (busy)
    );

    // Cache model: by default every enabled access hits and returns its own address.
    always_comb begin
        if (use_force) begin
            cache_data_available = force_status;
            cache_read_data      = force_data;
        end else begin
            cache_data_available = cache_enable ? 2'd2 : 2'd0;
            cache_read_data      = cache_addr[DW-1:0];
        end
    end

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [AW-1:0] pc, input logic [DW-1:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            step(1);
            n++;
        end
        check("drain_pending", EW'(exp_q.size()), '0);
    endtask

    task automatic redirect_now(input logic [AW-1:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step(1);
        redirect_valid = 1'b0;
    endtask

    // Monitor: a handshake is due at the next edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got pc=%0h instr=%0h, required no output", out_pc, out_instr);
            end else begin
                logic [EW-1:0] exp;
                exp = exp_q.pop_front();
                if ({out_pc, out_instr} !== exp) begin
                    bad++;
                    $display("FAIL out_entry: got pc=%0h instr=%0h, required pc=%0h instr=%0h",
                             out_pc, out_instr, exp[EW-1:DW], exp[DW-1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 reset = 1'b1;
        #2;
        check("rst_enable",  EW'(cache_enable), 0);
        check("rst_busy",    EW'(busy), 0);
        check("rst_valid",   EW'(out_valid), 0);
        check("rst_out_pc",  EW'(out_pc), 0);
        check("rst_instr",   EW'(out_instr), 0);
        check("rst_addr",    EW'(cache_addr), 0);
        step(1);
        reset = 1'b0;

        // Sequential hits from pc 0.
        run       = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_entry(AW'(i * 4), DW'(i * 4));
        step(4);
        run = 1'b0;
        wait_drain(10);
        check("seq_end_addr", EW'(cache_addr), 64'h10);
        check("seq_end_enable", EW'(cache_enable), 0);

        // Miss held for 20 cycles at 0x40; run drops mid-miss.
        redirect_now(64'h40);
        use_force    = 1'b1;
        force_status = 2'd3;
        run          = 1'b1;
        step(1);
        check("miss_addr_fetch", EW'(cache_addr), 64'h40);
        check("miss_flag", EW'(cache_rd_wr_evict_flag), 1);
        step(1);
        force_status = 2'd1;
        for (int i = 0; i < 20; i++) begin
            check("miss_addr_hold", EW'(cache_addr), 64'h40);
            if (i == 10) run = 1'b0;
            step(1);
        end
        check("miss_busy", EW'(busy), 1);
        force_status = 2'd2;
        force_data   = 32'hDEADBEEF;
        expect_entry(64'h40, 32'hDEADBEEF);
        step(1);
        use_force = 1'b0;
        check("miss_next_addr", EW'(cache_addr), 64'h44);
        check("miss_idle", EW'(busy), 0);
        wait_drain(10);

        // Backpressure: only FIFO_DEPTH entries, PC held, outputs stable.
        out_ready = 1'b0;
        redirect_now(64'h0);
        run = 1'b1;
        expect_entry(64'h0, 32'h0);
        expect_entry(64'h4, 32'h4);
        expect_entry(64'h8, 32'h8);
        step(5);
        check("bp_addr", EW'(cache_addr), 64'h8);
        check("bp_valid", EW'(out_valid), 1);
        check("bp_head", {out_pc, out_instr}, {64'h0, 32'h0});
        step(1);
        check("bp_addr_hold", EW'(cache_addr), 64'h8);
        check("bp_head_stable", {out_pc, out_instr}, {64'h0, 32'h0});
        out_ready = 1'b1;
        step(1);
        run = 1'b0;
        wait_drain(10);
        check("bp_end_addr", EW'(cache_addr), 64'hC);

        // Redirect on a hit with a full FIFO.
        out_ready = 1'b0;
        run       = 1'b1;
        step(3);
        check("rh_full_valid", EW'(out_valid), 1);
        run = 1'b0;
        redirect_now(64'h1002);
        check("rh_flushed", EW'(out_valid), 0);
        check("rh_addr", EW'(cache_addr), 64'h1000);

        // Redirect during a miss: address held, filled word discarded.
        out_ready = 1'b1;
        redirect_now(64'h80);
        use_force    = 1'b1;
        force_status = 2'd3;
        run          = 1'b1;
        step(2);
        force_status = 2'd1;
        redirect_now(64'h200);
        check("rm_flushed", EW'(out_valid), 0);
        for (int i = 0; i < 3; i++) begin
            check("rm_addr_hold", EW'(cache_addr), 64'h80);
            step(1);
        end
        force_status = 2'd2;
        force_data   = 32'h12345678;
        run          = 1'b0;
        step(1);
        use_force = 1'b0;
        check("rm_addr_new", EW'(cache_addr), 64'h200);
        step(2);
        check("rm_no_push", EW'(out_valid), 0);

        // Asynchronous reset in the middle of a miss with a buffered entry.
        out_ready = 1'b0;
        run       = 1'b1;
        step(2);
        use_force    = 1'b1;
        force_status = 2'd3;
        step(1);
        check("ar_busy_before", EW'(busy), 1);
        check("ar_valid_before", EW'(out_valid), 1);
        check("ar_addr_before", EW'(cache_addr), 64'h204);
        #2 reset = 1'b1;
        #1;
        check("ar_enable", EW'(cache_enable), 0);
        check("ar_valid", EW'(out_valid), 0);
        check("ar_addr", EW'(cache_addr), 0);
        check("ar_busy", EW'(busy), 0);
        check("ar_flag", EW'(cache_rd_wr_evict_flag), 0);
        step(1);
        reset     = 1'b0;
        use_force = 1'b0;
        run       = 1'b0;
        step(1);
        check("ar_idle_after", EW'(busy), 0);

        check("final_queue", EW'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
